// File: rtl/osc_multi_pkg.sv
// Shared types and helpers for the multi-channel emulated oscillator.
package osc_multi_pkg;

    // Wide enough to be truncated to any supported counter width as all-ones.
    localparam int unsigned DT_MAX_W = 64;
    localparam logic [DT_MAX_W-1:0] DT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    // A zero half-period would stall time; treat it as one unit.
    function automatic int unsigned clamp_per(input int unsigned p);
        return (p == 0) ? 1 : p;
    endfunction

endpackage

// File: rtl/osc_dt_min_tree.sv
// Balanced binary reduction of (valid, value) pairs to the minimum valid value.
module osc_dt_min_tree
    import osc_multi_pkg::*;
#(
    parameter int unsigned N_CH = 2,
    parameter int unsigned W    = 27
) (
    input  logic [N_CH-1:0]   i_valid,
    input  logic [N_CH*W-1:0] i_val,
    output logic [W-1:0]      o_min
);

    localparam int unsigned NP = 1 << $clog2(N_CH);

    // Heap layout: node i has children 2i+1 and 2i+2; leaves start at NP-1.
    logic         w_v [2*NP-1];
    logic [W-1:0] w_d [2*NP-1];

    for (genvar g = 0; g < NP; g++) begin : g_leaf
        if (g < N_CH) begin : g_real
            assign w_v[NP-1+g] = i_valid[g];
            assign w_d[NP-1+g] = i_val[g*W +: W];
        end else begin : g_pad
            assign w_v[NP-1+g] = 1'b0;
            assign w_d[NP-1+g] = '1;
        end
    end

    for (genvar i = 0; i < NP - 1; i++) begin : g_node
        assign w_v[i] = w_v[2*i+1] | w_v[2*i+2];
        assign w_d[i] = (w_v[2*i+1] && (!w_v[2*i+2] || (w_d[2*i+1] <= w_d[2*i+2])))
                      ? w_d[2*i+1] : w_d[2*i+2];
    end

    assign o_min = w_v[0] ? w_d[0] : W'(DT_MAX);

endmodule

// File: rtl/osc_model_multi.sv
// N-channel emulated clock generator with per-channel duty cycle and step request.
module osc_model_multi
    import osc_multi_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DT_WIDTH  = 27,
    parameter int unsigned PER_WIDTH = 24
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst_n,
    input  logic [DT_WIDTH-1:0]       emu_dt,
    output logic [DT_WIDTH-1:0]       emu_dt_req,
    input  logic [N_CH-1:0]           ch_en,
    input  logic [N_CH*PER_WIDTH-1:0] t_lo,
    input  logic [N_CH*PER_WIDTH-1:0] t_hi,
    output logic [N_CH-1:0]           clk_val,
    output logic [N_CH-1:0]           cke,
    output logic [N_CH-1:0]           overrun,
    input  logic                      overrun_clr
);

    logic [DT_WIDTH-1:0] r_emu_time;
    ch_state_t           r_state [N_CH];
    logic [DT_WIDTH-1:0] r_nxt   [N_CH];
    logic [N_CH-1:0]     r_clk_val;
    logic [N_CH-1:0]     r_overrun;

    logic [DT_WIDTH-1:0]      w_et_n;
    logic [DT_WIDTH-1:0]      w_rem   [N_CH];
    logic [DT_WIDTH-1:0]      w_lo    [N_CH];
    logic [DT_WIDTH-1:0]      w_hi    [N_CH];
    logic [N_CH*DT_WIDTH-1:0] w_rem_flat;
    logic [N_CH-1:0]          w_active;
    logic [N_CH-1:0]          w_edge;
    logic [N_CH-1:0]          w_miss;
    ch_state_t                w_state_n [N_CH];
    logic [DT_WIDTH-1:0]      w_nxt_n   [N_CH];
    logic [N_CH-1:0]          w_clk_n;
    logic [N_CH-1:0]          w_ovr_n;

    assign w_et_n = r_emu_time + emu_dt;

    // Periods are read straight from the inputs at each edge, so a change
    // mid-half-period only shapes the half-period that starts at the next edge.
    always_comb begin
        w_rem_flat = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            w_lo[c]     = DT_WIDTH'(clamp_per(32'(t_lo[c*PER_WIDTH +: PER_WIDTH])));
            w_hi[c]     = DT_WIDTH'(clamp_per(32'(t_hi[c*PER_WIDTH +: PER_WIDTH])));
            w_active[c] = (r_state[c] == RUN);
            w_rem[c]    = r_nxt[c] - r_emu_time;
            w_edge[c]   = w_active[c] && ch_en[c] && (emu_dt == w_rem[c]);
            w_miss[c]   = w_active[c] && ch_en[c] && (emu_dt > w_rem[c]);
            w_rem_flat[c*DT_WIDTH +: DT_WIDTH] = w_rem[c];
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < N_CH; c++) begin
            w_state_n[c] = r_state[c];
            w_nxt_n[c]   = r_nxt[c];
            w_clk_n[c]   = r_clk_val[c];
            w_ovr_n[c]   = r_overrun[c] & ~overrun_clr;
            case (r_state[c])
                IDLE: begin
                    if (ch_en[c]) begin
                        w_state_n[c] = RUN;
                        w_clk_n[c]   = 1'b0;
                        w_nxt_n[c]   = w_et_n + w_lo[c];
                    end
                end
                RUN: begin
                    if (!ch_en[c]) begin
                        w_state_n[c] = IDLE;
                        w_clk_n[c]   = 1'b0;
                    end else if (w_edge[c]) begin
                        w_clk_n[c] = ~r_clk_val[c];
                        w_nxt_n[c] = r_nxt[c] + (r_clk_val[c] ? w_lo[c] : w_hi[c]);
                    end else if (w_miss[c]) begin
                        w_ovr_n[c] = 1'b1;
                        w_clk_n[c] = ~r_clk_val[c];
                        w_nxt_n[c] = w_et_n + (r_clk_val[c] ? w_lo[c] : w_hi[c]);
                    end
                end
                default: w_state_n[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_emu_time <= '0;
            r_clk_val  <= '0;
            r_overrun  <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_state[c] <= IDLE;
                r_nxt[c]   <= '0;
            end
        end else begin
            r_emu_time <= w_et_n;
            r_clk_val  <= w_clk_n;
            r_overrun  <= w_ovr_n;
            for (int unsigned c = 0; c < N_CH; c++) begin
                r_state[c] <= w_state_n[c];
                r_nxt[c]   <= w_nxt_n[c];
            end
        end
    end

    osc_dt_min_tree #(
        .N_CH (N_CH),
        .W    (DT_WIDTH)
    ) u_min (
        .i_valid (w_active),
        .i_val   (w_rem_flat),
        .o_min   (emu_dt_req)
    );

    assign clk_val = r_clk_val;
    assign cke     = w_edge;
    assign overrun = r_overrun;

endmodule
